median_seq: RTL and testbench

MEDIAN_SEQ -- requirements
Module: median_seq

---
 rtl/median_seq.sv | 157 +++++++++++++++
 tb/tb_median_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/median_seq.sv
// Sequential median-of-9: loads 9 samples, then runs a 19-step compare-exchange network
// on one shared comparator. Optional MEDIAN_SEQ_STATUS_EN adds a done_cnt output.
module median_seq #(
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef MEDIAN_SEQ_STATUS_EN
  output logic [15:0]       done_cnt,
`endif
  input  logic              clr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data
);

  typedef enum logic [1:0] {LOAD, SORT, DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [4:0]        step_q, step_d;
  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] r_q [9];
  logic [DATA_W-1:0] r_d [9];

  logic [3:0]        idx_a, idx_b;
  logic [DATA_W-1:0] op_a, op_b, lo, hi;

  // Exchange schedule: {low index, high index} per step.
  always_comb begin
    unique case (step_q)
      5'd0:    {idx_a, idx_b} = 8'h01;
      5'd1:    {idx_a, idx_b} = 8'h34;
      5'd2:    {idx_a, idx_b} = 8'h67;
      5'd3:    {idx_a, idx_b} = 8'h12;
      5'd4:    {idx_a, idx_b} = 8'h45;
      5'd5:    {idx_a, idx_b} = 8'h78;
      5'd6:    {idx_a, idx_b} = 8'h01;
      5'd7:    {idx_a, idx_b} = 8'h34;
      5'd8:    {idx_a, idx_b} = 8'h67;
      5'd9:    {idx_a, idx_b} = 8'h03;
      5'd10:   {idx_a, idx_b} = 8'h14;
      5'd11:   {idx_a, idx_b} = 8'h58;
      5'd12:   {idx_a, idx_b} = 8'h36;
      5'd13:   {idx_a, idx_b} = 8'h47;
      5'd14:   {idx_a, idx_b} = 8'h25;
      5'd15:   {idx_a, idx_b} = 8'h14;
      5'd16:   {idx_a, idx_b} = 8'h46;
      5'd17:   {idx_a, idx_b} = 8'h26;
      5'd18:   {idx_a, idx_b} = 8'h24;
      default: {idx_a, idx_b} = 8'h01;
    endcase
  end

  // Shared compare-exchange; equal operands pass through unchanged.
  always_comb begin
    op_a = r_q[idx_a];
    op_b = r_q[idx_b];
    lo   = (op_a > op_b) ? op_b : op_a;
    hi   = (op_a > op_b) ? op_a : op_b;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    step_d    = step_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    r_d       = r_q;
    s_ready   = (state_q == LOAD);
    unique case (state_q)
      LOAD: if (s_valid) begin
        r_d[cnt_q] = s_data;
        if (cnt_q == 4'd8) begin
          cnt_d   = 4'd0;
          step_d  = 5'd0;
          state_d = SORT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      SORT: begin
        r_d[idx_a] = lo;
        r_d[idx_b] = hi;
        if (step_q == 5'd18) begin
          m_data_d  = hi;
          m_valid_d = 1'b1;
          step_d    = 5'd0;
          state_d   = DONE;
        end else begin
          step_d = step_q + 5'd1;
        end
      end
      DONE: if (m_ready) begin
        m_valid_d = 1'b0;
        cnt_d     = 4'd0;
        state_d   = LOAD;
      end
      default: state_d = LOAD;
    endcase
    if (clr) begin
      state_d   = LOAD;
      cnt_d     = 4'd0;
      step_d    = 5'd0;
      m_valid_d = 1'b0;
      m_data_d  = m_data_q;
      r_d       = r_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      cnt_q     <= 4'd0;
      step_q    <= 5'd0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      step_q    <= step_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  // Sample store is fully rewritten before every sort, so it carries no reset.
  always_ff @(posedge clk) begin
    r_q <= r_d;
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

`ifdef MEDIAN_SEQ_STATUS_EN
  logic [15:0] done_cnt_q, done_cnt_d;

  // A handshake coincident with clr still counts as delivered.
  always_comb begin
    done_cnt_d = done_cnt_q;
    if (m_valid_q && m_ready && (done_cnt_q != 16'hFFFF))
      done_cnt_d = done_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_cnt_q <= 16'd0;
    else        done_cnt_q <= done_cnt_d;
  end

  assign done_cnt = done_cnt_q;
`endif

endmodule

// File: tb/tb_median_seq.sv
// Directed + randomized bench for median_seq; reference median comes from a sorted queue.
module tb_median_seq;
  typedef logic [8:0] win_t [9];

  logic       clk = 1'b0;
  logic       rst_n, clr, s_valid, s_ready, m_valid, m_ready;
  logic [8:0] s_data, m_data;
`ifdef MEDIAN_SEQ_STATUS_EN
  logic [15:0] done_cnt;
`endif
  int total = 0;
  int bad   = 0;
  int ndone = 0;

  median_seq #(.DATA_W(9)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MEDIAN_SEQ_STATUS_EN
    .done_cnt(done_cnt),
`endif
    .clr(clr), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] med(input win_t v);
    int q[$];
    logic [8:0] r;
    for (int i = 0; i < 9; i++) q.push_back(int'(v[i]));
    q.sort();
    r = 9'(q[4]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends v[lo..hi-1]; optional random idle gaps before each sample.
  task automatic feed(input win_t v, input int lo, input int hi, input bit gap);
    for (int i = lo; i < hi; i++) begin
      if (gap) repeat ($urandom_range(0, 3)) tick();
      s_valid = 1'b1;
      s_data  = v[i];
      check("s_ready_load", s_ready, 1);
      tick();
      s_valid = 1'b0;
    end
  endtask

  // Waits for the median after the 9th accept, checks latency/value, then drains.
  task automatic collect(input win_t v, input int hold);
    int lat = 99;
    m_ready = (hold == 0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (m_valid) begin
        lat = k;
        break;
      end
    end
    check("latency", lat, 19);
    check("m_data", m_data, med(v));
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", m_valid, 1);
      check("hold_data", m_data, med(v));
      check("hold_sready", s_ready, 0);
    end
    m_ready = 1'b1;
    tick();
    ndone++;
    check("valid_drop", m_valid, 0);
    check("sready_back", s_ready, 1);
  endtask

  task automatic run(input win_t v, input bit gap, input int hold);
    m_ready = (hold == 0);
    feed(v, 0, 9, gap);
    collect(v, hold);
  endtask

  initial begin
    win_t w;
    rst_n = 1'b0; clr = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    tick();
    tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    rst_n = 1'b1;
    tick();
    check("rst_s_ready", s_ready, 1);

    for (int i = 0; i < 9; i++) w[i] = 9'(i + 1);
    run(w, 1'b0, 0);
    for (int i = 0; i < 9; i++) w[i] = 9'(9 - i);
    run(w, 1'b0, 0);
    for (int i = 0; i < 9; i++) w[i] = 9'h1FF;
    run(w, 1'b0, 0);
    for (int i = 0; i < 8; i++) w[i] = (i % 2 == 0) ? 9'h1FF : 9'h000;
    w[8] = 9'd7;
    run(w, 1'b0, 0);

    // Backpressure in DONE
    for (int i = 0; i < 9; i++) w[i] = 9'(i + 1);
    run(w, 1'b0, 10);

    // Abort mid-SORT with clr, then a fresh window
    for (int i = 0; i < 9; i++) w[i] = 9'($urandom_range(0, 511));
    feed(w, 0, 9, 1'b0);
    repeat (10) begin
      tick();
      check("sort_no_valid", m_valid, 0);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_valid", m_valid, 0);
    check("clr_sready", s_ready, 1);
    for (int i = 0; i < 9; i++) w[i] = 9'(2 * (i + 1));
    run(w, 1'b0, 0);
    check("clr_keeps_data", m_data, 10);

    // Partial window, then clr with a coincident sample that must be dropped
    for (int i = 0; i < 9; i++) w[i] = 9'($urandom_range(0, 511));
    feed(w, 0, 4, 1'b0);
    s_valid = 1'b1; s_data = 9'h155; clr = 1'b1;
    tick();
    s_valid = 1'b0; clr = 1'b0;
    run(w, 1'b0, 0);

    // Partial window persisting through a long stall
    for (int i = 0; i < 9; i++) w[i] = 9'($urandom_range(0, 511));
    m_ready = 1'b1;
    feed(w, 0, 5, 1'b1);
    repeat (30) tick();
    check("stall_sready", s_ready, 1);
    feed(w, 5, 9, 1'b1);
    collect(w, 0);

    // Gapped 1..9, three windows
    for (int i = 0; i < 9; i++) w[i] = 9'(i + 1);
    repeat (3) run(w, 1'b1, 0);

    // Random windows, some narrow-range to force equal operands
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 9; i++)
        w[i] = (n % 2 == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 3));
      run(w, n[0], n % 3);
    end

    // Handshake coincident with clr counts as a transfer
    for (int i = 0; i < 9; i++) w[i] = 9'($urandom_range(0, 511));
    m_ready = 1'b0;
    feed(w, 0, 9, 1'b0);
    repeat (20) tick();
    check("pre_clr_valid", m_valid, 1);
    check("pre_clr_data", m_data, med(w));
    m_ready = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    ndone++;
    check("clr_hs_valid", m_valid, 0);
    check("clr_hs_data", m_data, med(w));
`ifdef MEDIAN_SEQ_STATUS_EN
    check("done_cnt", done_cnt, ndone);
`endif

    // Async reset mid-SORT abandons the window and zeros m_data
    for (int i = 0; i < 9; i++) w[i] = 9'(100 + i);
    feed(w, 0, 9, 1'b0);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", m_valid, 0);
    check("rst_mid_data", m_data, 0);
    check("rst_mid_sready", s_ready, 1);
`ifdef MEDIAN_SEQ_STATUS_EN
    check("rst_done_cnt", done_cnt, 0);
`endif
    tick();
    rst_n = 1'b1;
    ndone = 0;
    repeat (25) begin
      tick();
      check("rst_no_out", m_valid, 0);
    end
    for (int i = 0; i < 9; i++) w[i] = 9'(i + 1);
    run(w, 1'b1, 0);
`ifdef MEDIAN_SEQ_STATUS_EN
    check("done_cnt_final", done_cnt, ndone);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
